// File: rtl/matrix_commit_buffer_if.sv
// Issue, commit and release channels between the core, the commit buffer
// and the matrix accelerator decoder.
interface matrix_commit_buffer_if #(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                issue_valid;
  logic                issue_ready;
  logic [31:0]         issue_instr;
  logic [ID_WIDTH-1:0] issue_id;
  logic [XLEN-1:0]     issue_rs1;
  logic [XLEN-1:0]     issue_rs2;
  logic                issue_accept;

  logic                commit_valid;
  logic [ID_WIDTH-1:0] commit_id;
  logic                commit_kill;
  logic                commit_miss;

  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [ID_WIDTH-1:0] out_id;
  logic [XLEN-1:0]     out_rs1;
  logic [XLEN-1:0]     out_rs2;

  logic [CNT_W-1:0]    count;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2,
    output commit_valid, commit_id, commit_kill, out_ready,
    input  issue_ready, issue_accept, commit_miss,
    input  out_valid, out_instr, out_id, out_rs1, out_rs2, count
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2,
    input  commit_valid, commit_id, commit_kill, out_ready,
    output issue_ready, issue_accept, commit_miss,
    output out_valid, out_instr, out_id, out_rs1, out_rs2, count
  );
endinterface

// File: rtl/matrix_commit_buffer.sv
// In-order speculation buffer: holds offloaded matrix instructions until the
// core commits them, drops killed ones, and releases only committed work.
module matrix_commit_buffer #(
  parameter logic [6:0]  OPCODE   = 7'h2B,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned XLEN     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_commit_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]         instr_q [DEPTH];
  logic [ID_WIDTH-1:0] id_q    [DEPTH];
  logic [XLEN-1:0]     rs1_q   [DEPTH];
  logic [XLEN-1:0]     rs2_q   [DEPTH];
  logic [DEPTH-1:0]    committed_q;
  logic [DEPTH-1:0]    killed_q;
  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;
  logic                commit_miss_q;

  logic             match;
  logic             not_full;
  logic             push;
  logic             pop;
  logic             head_ready;
  logic             head_drop;
  logic             hit_found;
  logic [PTR_W-1:0] hit_idx;
  logic             push_resolved;
  logic             miss;

  assign match    = (bus.issue_instr[6:0] == OPCODE);
  assign not_full = (count_q < CNT_W'(DEPTH));
  assign push     = bus.issue_valid && match && not_full;

  // Search from head so the oldest unresolved entry with the id wins.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!hit_found && bus.commit_valid && (CNT_W'(k) < count_q) &&
          (id_q[head_q + PTR_W'(k)] == bus.commit_id) &&
          !committed_q[head_q + PTR_W'(k)] && !killed_q[head_q + PTR_W'(k)]) begin
        hit_found = 1'b1;
        hit_idx   = head_q + PTR_W'(k);
      end
    end
  end

  // A commit that finds no older entry resolves the instruction being pushed.
  assign push_resolved = bus.commit_valid && !hit_found && push &&
                         (bus.issue_id == bus.commit_id);
  assign miss          = bus.commit_valid && !hit_found && !push_resolved;

  assign head_ready = (count_q != '0) && committed_q[head_q];
  assign head_drop  = (count_q != '0) && killed_q[head_q];
  assign pop        = head_drop || (head_ready && bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed_q   <= '0;
      killed_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_miss_q <= 1'b0;
    end else begin
      if (pop) begin
        committed_q[head_q] <= 1'b0;
        killed_q[head_q]    <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      if (push) begin
        committed_q[tail_q] <= push_resolved && !bus.commit_kill;
        killed_q[tail_q]    <= push_resolved && bus.commit_kill;
        tail_q              <= tail_q + PTR_W'(1);
      end
      if (hit_found) begin
        if (bus.commit_kill) killed_q[hit_idx]    <= 1'b1;
        else                 committed_q[hit_idx] <= 1'b1;
      end
      count_q       <= count_q + CNT_W'(push) - CNT_W'(pop);
      commit_miss_q <= miss;
    end
  end

  // Payload storage carries no reset; only the flags decide occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q] <= bus.issue_instr;
      id_q[tail_q]    <= bus.issue_id;
      rs1_q[tail_q]   <= bus.issue_rs1;
      rs2_q[tail_q]   <= bus.issue_rs2;
    end
  end

  assign bus.issue_ready  = match ? not_full : 1'b1;
  assign bus.issue_accept = match && not_full;
  assign bus.commit_miss  = commit_miss_q;
  assign bus.out_valid    = head_ready;
  assign bus.out_instr    = instr_q[head_q];
  assign bus.out_id       = id_q[head_q];
  assign bus.out_rs1      = rs1_q[head_q];
  assign bus.out_rs2      = rs2_q[head_q];
  assign bus.count        = count_q;
endmodule

// File: tb/tb_matrix_commit_buffer.sv
// Bench for matrix_commit_buffer: queue-based reference model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_matrix_commit_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ID_WIDTH = 4;
  localparam int unsigned XLEN     = 64;
  localparam logic [6:0]  OPCODE   = 7'h2B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_commit_buffer_if #(.ID_WIDTH(ID_WIDTH), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  matrix_commit_buffer #(
    .OPCODE(OPCODE), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of outstanding instructions.
  typedef enum int {M_PEND, M_DONE, M_KILL} mstate_e;
  typedef struct {
    logic [31:0]         instr;
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    mstate_e             st;
  } ment_t;

  ment_t mq[$];
  bit    exp_miss = 1'b0;

  task automatic model_step();
    bit      match;
    bit      push;
    bit      same;
    bit      pop;
    int      hit;
    mstate_e res;
    ment_t   e;
    match = (bus.issue_instr[6:0] == OPCODE);
    push  = bus.issue_valid && match && (mq.size() < DEPTH);
    res   = bus.commit_kill ? M_KILL : M_DONE;
    hit   = -1;
    if (bus.commit_valid) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].id == bus.commit_id && mq[i].st == M_PEND) begin
          hit = i;
          break;
        end
      end
    end
    same     = bus.commit_valid && (hit < 0) && push && (bus.issue_id == bus.commit_id);
    exp_miss = bus.commit_valid && (hit < 0) && !same;
    pop      = (mq.size() > 0) && (mq[0].st == M_KILL || (mq[0].st == M_DONE && bus.out_ready));
    if (hit >= 0) begin
      e = mq[hit];
      e.st = res;
      mq[hit] = e;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.instr = bus.issue_instr;
      e.id    = bus.issue_id;
      e.rs1   = bus.issue_rs1;
      e.rs2   = bus.issue_rs2;
      e.st    = same ? res : M_PEND;
      mq.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      exp_miss = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic compare();
    bit match;
    bit room;
    bit ev;
    int n;
    n     = mq.size();
    match = (bus.issue_instr[6:0] == OPCODE);
    room  = (n < DEPTH);
    ev    = (n > 0) && (mq[0].st == M_DONE);
    chk("count", 64'(bus.count), 64'(n));
    chk("issue_ready", 64'(bus.issue_ready), 64'(match ? room : 1'b1));
    chk("issue_accept", 64'(bus.issue_accept), 64'(match && room));
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("commit_miss", 64'(bus.commit_miss), 64'(exp_miss));
    if (ev) begin
      chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
      chk("out_id", 64'(bus.out_id), 64'(mq[0].id));
      chk("out_rs1", bus.out_rs1, mq[0].rs1);
      chk("out_rs2", bus.out_rs2, mq[0].rs2);
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.issue_valid  = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [ID_WIDTH-1:0] id,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_instr = ins;
    bus.issue_id    = id;
    bus.issue_rs1   = a;
    bus.issue_rs2   = b;
  endtask

  task automatic commit(input logic [ID_WIDTH-1:0] id, input bit kill);
    bus.commit_valid = 1'b1;
    bus.commit_id    = id;
    bus.commit_kill  = kill;
  endtask

  initial begin
    logic [31:0] ins;
    bus.issue_valid  = 1'b0;
    bus.issue_instr  = 32'h0;
    bus.issue_id     = '0;
    bus.issue_rs1    = '0;
    bus.issue_rs2    = '0;
    bus.commit_valid = 1'b0;
    bus.commit_id    = '0;
    bus.commit_kill  = 1'b0;
    bus.out_ready    = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    at_neg();
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_commit_miss", 64'(bus.commit_miss), 64'd0);

    // Basic flow: issue at cycle 0, commit at cycle 2, visible at cycle 3.
    cyc(); issue(32'h0000_002B, 4'd3, 64'h10, 64'h20);
    at_neg(); chk("basic_accept", 64'(bus.issue_accept), 64'd1);
    cyc(); idle();
    at_neg(); chk("basic_pending", 64'(bus.out_valid), 64'd0);
    cyc(); commit(4'd3, 1'b0);
    at_neg(); chk("basic_not_yet", 64'(bus.out_valid), 64'd0);
    cyc(); idle(); bus.out_ready = 1'b1;
    at_neg();
    chk("basic_out_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_out_id", 64'(bus.out_id), 64'd3);
    chk("basic_out_instr", 64'(bus.out_instr), 64'h2B);
    chk("basic_out_rs1", bus.out_rs1, 64'h10);
    chk("basic_out_rs2", bus.out_rs2, 64'h20);
    chk("basic_count1", 64'(bus.count), 64'd1);
    cyc(); bus.out_ready = 1'b0;
    at_neg(); chk("basic_count0", 64'(bus.count), 64'd0);

    // Opcode mismatch is handshaken but not stored.
    cyc(); issue(32'h0000_0033, 4'd7, 64'h1, 64'h2);
    at_neg();
    chk("mismatch_ready", 64'(bus.issue_ready), 64'd1);
    chk("mismatch_accept", 64'(bus.issue_accept), 64'd0);
    cyc(); idle();
    at_neg(); chk("mismatch_count", 64'(bus.count), 64'd0);

    // Fill to DEPTH, then backpressure until a pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      cyc(); issue(32'h0000_002B, ID_WIDTH'(i), 64'(i + 100), 64'(i + 200));
    end
    cyc(); issue(32'h0000_002B, 4'd4, 64'h104, 64'h204);
    at_neg();
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_ready", 64'(bus.issue_ready), 64'd0);
    cyc(); commit(4'd0, 1'b0);
    at_neg(); chk("full_ready_hold", 64'(bus.issue_ready), 64'd0);
    cyc(); bus.commit_valid = 1'b0; bus.out_ready = 1'b1;
    at_neg();
    chk("full_head_id", 64'(bus.out_id), 64'd0);
    chk("full_no_pop_aware", 64'(bus.issue_ready), 64'd0);
    cyc(); bus.out_ready = 1'b0;
    at_neg();
    chk("full_after_pop_count", 64'(bus.count), 64'd3);
    chk("full_after_pop_accept", 64'(bus.issue_accept), 64'd1);
    cyc(); idle();
    at_neg(); chk("full_refill", 64'(bus.count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      cyc(); commit(ID_WIDTH'(i), 1'b0); bus.out_ready = 1'b1;
    end
    repeat (3) begin cyc(); idle(); end
    at_neg(); chk("full_drained", 64'(bus.count), 64'd0);

    // Kill ordering: a killed head costs exactly one cycle.
    cyc(); issue(32'h0000_002B, 4'd1, 64'h11, 64'h21);
    cyc(); issue(32'h0000_002B, 4'd2, 64'h12, 64'h22);
    cyc(); issue(32'h0000_002B, 4'd3, 64'h13, 64'h23);
    cyc(); bus.issue_valid = 1'b0; commit(4'd2, 1'b1);
    cyc(); commit(4'd1, 1'b0);
    cyc(); commit(4'd3, 1'b0);
    at_neg();
    chk("kill_first_valid", 64'(bus.out_valid), 64'd1);
    chk("kill_first_id", 64'(bus.out_id), 64'd1);
    chk("kill_first_count", 64'(bus.count), 64'd3);
    cyc(); idle();
    at_neg();
    chk("kill_drop_valid", 64'(bus.out_valid), 64'd0);
    chk("kill_drop_count", 64'(bus.count), 64'd2);
    cyc();
    at_neg();
    chk("kill_second_valid", 64'(bus.out_valid), 64'd1);
    chk("kill_second_id", 64'(bus.out_id), 64'd3);
    cyc();
    at_neg(); chk("kill_count0", 64'(bus.count), 64'd0);

    // Same-cycle issue and commit, then a commit that finds nothing.
    cyc(); bus.out_ready = 1'b0;
    issue(32'h0000_002B, 4'd5, 64'h55, 64'h66); commit(4'd5, 1'b0);
    cyc(); idle(); bus.out_ready = 1'b1;
    at_neg();
    chk("same_valid", 64'(bus.out_valid), 64'd1);
    chk("same_id", 64'(bus.out_id), 64'd5);
    chk("same_no_miss", 64'(bus.commit_miss), 64'd0);
    cyc(); bus.out_ready = 1'b0; commit(4'd9, 1'b0);
    at_neg(); chk("miss_before", 64'(bus.commit_miss), 64'd0);
    cyc(); idle();
    at_neg(); chk("miss_pulse", 64'(bus.commit_miss), 64'd1);
    cyc();
    at_neg(); chk("miss_clear", 64'(bus.commit_miss), 64'd0);

    // Reset with entries held discards them immediately.
    cyc(); issue(32'h0000_002B, 4'd6, 64'h6, 64'h6);
    cyc(); issue(32'h0000_002B, 4'd7, 64'h7, 64'h7);
    cyc(); issue(32'h0000_002B, 4'd8, 64'h8, 64'h8); commit(4'd6, 1'b0);
    cyc(); idle();
    at_neg();
    chk("prerst_count", 64'(bus.count), 64'd3);
    chk("prerst_valid", 64'(bus.out_valid), 64'd1);
    cyc(); rst = 1'b1;
    #1;
    chk("rst_now_count", 64'(bus.count), 64'd0);
    chk("rst_now_valid", 64'(bus.out_valid), 64'd0);
    cyc(); rst = 1'b0;
    issue(32'h0000_002B, 4'd10, 64'hA, 64'hB); commit(4'd10, 1'b0);
    cyc(); idle(); bus.out_ready = 1'b1;
    at_neg();
    chk("postrst_valid", 64'(bus.out_valid), 64'd1);
    chk("postrst_id", 64'(bus.out_id), 64'd10);
    cyc(); bus.out_ready = 1'b0;
    at_neg(); chk("postrst_count", 64'(bus.count), 64'd0);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = OPCODE;
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_instr = ins;
      bus.issue_id    = ID_WIDTH'($urandom);
      bus.issue_rs1   = {$urandom, $urandom};
      bus.issue_rs2   = {$urandom, $urandom};
      bus.commit_valid = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        bus.commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
      else
        bus.commit_id = ID_WIDTH'($urandom);
      bus.commit_kill = ($urandom_range(0, 3) == 0);
      bus.out_ready   = ($urandom_range(0, 9) < 7);
    end
    cyc(); idle(); rst = 1'b0;
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
